tlul_sram_slave: RTL and testbench
==================================

Name: tlul_sram_slave

Overview:
TL-UL responder endpoint: SRAM-backed slave that sits on the slave socket of the interconnect, in the 24 MHz peripheral domain. It consumes Channel A requests (Get, PutFullData, PutPartialData) and produces ordered Channel D responses (AccessAck, AccessAckData). Responses are buffered in a small FIFO so D-channel backpressure never corrupts state. It is the other end of the interconnect's slave socket and is used as the default bench and integration slave.

Parameters:
ADDR_WIDTH, 32, request address width
DATA_WIDTH, 32, data width
MASK_WIDTH, DATA_WIDTH/8, byte-lane mask width
SIZE_WIDTH, 3, TL size field width
SRC_WIDTH, 2, source ID width
SINK_WIDTH, 1, sink ID width
OPCODE_WIDTH, 3, opcode width
PARAM_WIDTH, 3, param width
BASE_ADDR, 32'h0000_0000, first byte address served
MEM_DEPTH, 1024, number of DATA_WIDTH words (power of 2)
RSP_FIFO_DEPTH, 2, response FIFO entries (>=1)
WAIT_CYCLES, 3, added response latency (optional feature only)

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-low reset
a_valid  in  1  request valid
a_ready  out  1  request accepted when a_valid&&a_ready
a_opcode  in  OPCODE_WIDTH  0=PutFull, 1=PutPartial, 4=Get
a_param  in  PARAM_WIDTH  ignored
a_size  in  SIZE_WIDTH  log2 bytes
a_source  in  SRC_WIDTH  requester ID
a_address  in  ADDR_WIDTH  byte address
a_mask  in  MASK_WIDTH  byte-lane enables
a_data  in  DATA_WIDTH  write data
d_valid  out  1  response valid
d_ready  in  1  response consumed when d_valid&&d_ready
d_opcode  out  OPCODE_WIDTH  0=AccessAck, 1=AccessAckData
d_param  out  PARAM_WIDTH  always 0
d_size  out  SIZE_WIDTH  echo of a_size
d_source  out  SRC_WIDTH  echo of a_source
d_sink  out  SINK_WIDTH  always 0
d_data  out  DATA_WIDTH  read data (0 for AccessAck or error)
d_error  out  1  request was erroneous

Behaviour:
- Reset (reset=0, async): FIFO emptied, d_valid=0, a_ready=0, all d_* fields=0, FSM to IDLE. Memory contents are not reset. In-flight responses are dropped. a_ready rises in the first cycle after release.
- a_ready = !fifo_full (registered count). It does not depend on a_valid or d_ready. When full, a_ready=0 even if a pop occurs in the same cycle.
- Error decode on accept. d_error=1 if any of:
  - opcode not in {0,1,4};
  - a_size > log2(MASK_WIDTH);
  - a_address not aligned to 2^a_size;
  - address outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*MASK_WIDTH);
  - PutFullData with a_size==log2(MASK_WIDTH) and a_mask not all ones.
- Word index = (a_address-BASE_ADDR)>>log2(MASK_WIDTH).
- Put, no error: bytes with a_mask=1 are written at the accepting edge. a_mask=0 writes nothing and returns a normal AccessAck. Erroneous Puts never write.
- Get, no error: the word read at the accepting edge is stored in the FIFO entry. A Get on the cycle after a Put to the same word returns the new data. Erroneous Get: d_data=0.
- Response entry: opcode = 1 for Get and 0 for all others (including bad opcode); param=0; sink=0; size and source echoed from the request.
- Latency: accept at edge N puts the response at the FIFO head with d_valid=1 in cycle N+1 at the earliest. Responses are returned strictly in acceptance order.
- D stability: while d_valid&&!d_ready, all d_* hold. Pop occurs on d_valid&&d_ready.
- Simultaneous push and pop on a non-full FIFO: count unchanged, no loss.
- Pointers wrap modulo RSP_FIFO_DEPTH.

Optional Feature:
TLUL_SLAVE_WAIT_STATES_EN
- Defined: FSM with states IDLE and BUSY.
  - a_ready = (IDLE && !fifo_full).
  - On accept, the memory access happens as above and the FSM enters BUSY with counter=WAIT_CYCLES.
  - The counter decrements each cycle. At 0, the response is pushed to the FIFO and the FSM returns to IDLE.
  - Latency: accept at N gives d_valid at N+1+WAIT_CYCLES.
  - WAIT_CYCLES=0 matches the undefined behaviour except that a_ready is low for one cycle after each accept.
- Undefined: no FSM or counter; zero added latency.

Test Plan:
- PutFull addr 0x10, data 0xDEADBEEF, mask 0xF, src 2; then Get 0x10, src 1 -> AccessAck src2 err0, then AccessAckData data 0xDEADBEEF src1; each d_valid 1 cycle after its accept.
- PutPartial addr 0x10, mask 0b0011, data 0x12345678, then Get 0x10 -> d_data 0xDEAD5678.
- Get 0x1000 (MEM_DEPTH=1024) -> opcode 1, d_error=1, d_data=0. Opcode 3 -> AccessAck, d_error=1. PutFull size 2 at addr 0x2 -> d_error=1, memory unchanged.
- d_ready=0, three back-to-back Gets -> two accepted, a_ready=0 after the second, d_* stable. Raise d_ready -> responses in order, third request accepted the cycle after the first pop.
- Assert reset with 2 responses queued -> d_valid=0 and a_ready=0 immediately (asynchronous). After release, FIFO empty and a_ready=1 the next cycle.
- Macro defined, WAIT_CYCLES=3: accept at cycle 0 -> d_valid at cycle 4, a_ready low in cycles 1-4.

Source files
------------

// File: rtl/tlul_sram_slave.sv
// TL-UL SRAM responder: serves Get / PutFullData / PutPartialData and returns in-order AccessAck(Data).
// Latency: response at the D head one cycle after the A accept (1 + WAIT_CYCLES with wait states).
// Backpressure: a_ready drops when the response FIFO is full; D outputs hold while d_ready is low.
//
// Ports: clk/reset (async active-low); A channel request (a_*), D channel response (d_*).
// Optional build macro TLUL_SLAVE_WAIT_STATES_EN adds an IDLE/BUSY wait-state FSM that delays
// each response by WAIT_CYCLES and blocks new requests while a response is pending.
module tlul_sram_slave #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    MASK_WIDTH     = DATA_WIDTH / 8,
    parameter int                    SIZE_WIDTH     = 3,
    parameter int                    SRC_WIDTH      = 2,
    parameter int                    SINK_WIDTH     = 1,
    parameter int                    OPCODE_WIDTH   = 3,
    parameter int                    PARAM_WIDTH    = 3,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    MEM_DEPTH      = 1024,
    parameter int                    RSP_FIFO_DEPTH = 2,
    parameter int                    WAIT_CYCLES    = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [OPCODE_WIDTH-1:0] a_opcode,
    input  logic [PARAM_WIDTH-1:0]  a_param,
    input  logic [SIZE_WIDTH-1:0]   a_size,
    input  logic [SRC_WIDTH-1:0]    a_source,
    input  logic [ADDR_WIDTH-1:0]   a_address,
    input  logic [MASK_WIDTH-1:0]   a_mask,
    input  logic [DATA_WIDTH-1:0]   a_data,
    output logic                    d_valid,
    input  logic                    d_ready,
    output logic [OPCODE_WIDTH-1:0] d_opcode,
    output logic [PARAM_WIDTH-1:0]  d_param,
    output logic [SIZE_WIDTH-1:0]   d_size,
    output logic [SRC_WIDTH-1:0]    d_source,
    output logic [SINK_WIDTH-1:0]   d_sink,
    output logic [DATA_WIDTH-1:0]   d_data,
    output logic                    d_error
);

    localparam int LG_MASK = $clog2(MASK_WIDTH);
    localparam int IDX_W   = $clog2(MEM_DEPTH);
    localparam int PTR_W   = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(RSP_FIFO_DEPTH + 1);

    localparam logic [ADDR_WIDTH:0]     MEM_BYTES   = (ADDR_WIDTH + 1)'(MEM_DEPTH * MASK_WIDTH);
    localparam logic [PTR_W-1:0]        PTR_LAST    = PTR_W'(RSP_FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]        CNT_FULL    = CNT_W'(RSP_FIFO_DEPTH);
    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PART = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_GET      = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] D_ACK       = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] D_ACK_DATA  = OPCODE_WIDTH'(1);

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] opcode;
        logic [SIZE_WIDTH-1:0]   size;
        logic [SRC_WIDTH-1:0]    source;
        logic [DATA_WIDTH-1:0]   data;
        logic                    error;
    } rsp_t;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // ---------------- request decode ----------------
    logic [ADDR_WIDTH:0]   off_ext;
    logic [ADDR_WIDTH-1:0] align_mask;
    logic [IDX_W-1:0]      widx;
    logic                  is_get, is_put, req_err, accept, wr_en;
    rsp_t                  new_rsp;

    always_comb begin
        // One extra bit keeps the borrow: addresses below BASE_ADDR land above MEM_BYTES.
        off_ext    = {1'b0, a_address} - {1'b0, BASE_ADDR};
        align_mask = (ADDR_WIDTH'(1) << a_size) - ADDR_WIDTH'(1);
        widx       = off_ext[LG_MASK +: IDX_W];
        is_get     = (a_opcode == OP_GET);
        is_put     = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART);
        req_err    = 1'b0;
        if (!is_get && !is_put)                    req_err = 1'b1;
        if (a_size > SIZE_WIDTH'(LG_MASK))         req_err = 1'b1;
        if ((a_address & align_mask) != '0)        req_err = 1'b1;
        if (off_ext >= MEM_BYTES)                  req_err = 1'b1;
        if ((a_opcode == OP_PUT_FULL) && (a_size == SIZE_WIDTH'(LG_MASK)) && (a_mask != '1))
            req_err = 1'b1;

        new_rsp.opcode = is_get ? D_ACK_DATA : D_ACK;
        new_rsp.size   = a_size;
        new_rsp.source = a_source;
        new_rsp.error  = req_err;
        new_rsp.data   = (is_get && !req_err) ? mem_q[widx] : '0;
    end

    assign accept = a_valid && a_ready;
    assign wr_en  = accept && is_put && !req_err;

    // Memory contents survive reset; only masked bytes of clean Puts are written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
                if (a_mask[b]) mem_q[widx][8*b +: 8] <= a_data[8*b +: 8];
            end
        end
    end

    // ---------------- response FIFO ----------------
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy_en_q;
    rsp_t             fifo_q [RSP_FIFO_DEPTH];
    logic             push, pop, full;
    rsp_t             push_rsp, head;

    assign full    = (cnt_q == CNT_FULL);
    assign d_valid = (cnt_q != '0);
    assign pop     = d_valid && d_ready;
    assign head    = fifo_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    // rdy_en_q holds a_ready low through reset and releases it one edge later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_en_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < RSP_FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push) fifo_q[wr_ptr_q] <= push_rsp;
        end
    end

    // Zero the D fields whenever nothing is presented.
    assign d_opcode = d_valid ? head.opcode : '0;
    assign d_size   = d_valid ? head.size   : '0;
    assign d_source = d_valid ? head.source : '0;
    assign d_data   = d_valid ? head.data   : '0;
    assign d_error  = d_valid ? head.error  : 1'b0;
    assign d_param  = '0;
    assign d_sink   = '0;

`ifdef TLUL_SLAVE_WAIT_STATES_EN
    localparam int WC_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    rsp_t             hold_q, hold_d;

    assign a_ready = rdy_en_q && !full && (state_q == IDLE);

    // BUSY lasts WAIT_CYCLES+1 cycles; the response is pushed on the edge where the
    // counter leaves 1 (or on the accept edge itself when WAIT_CYCLES is 0), so it
    // reaches the D head WAIT_CYCLES cycles later than in the no-wait build.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        hold_d  = hold_q;
        if (state_q == IDLE) begin
            if (accept) begin
                state_d = BUSY;
                wcnt_d  = WC_W'(WAIT_CYCLES);
                hold_d  = new_rsp;
            end
        end else if (wcnt_q == '0) begin
            state_d = IDLE;
        end else begin
            wcnt_d = wcnt_q - WC_W'(1);
        end
    end

    // FIFO space is guaranteed: nothing else pushes while BUSY.
    assign push     = (accept && (WAIT_CYCLES == 0)) || ((state_q == BUSY) && (wcnt_q == WC_W'(1)));
    assign push_rsp = accept ? new_rsp : hold_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            hold_q  <= hold_d;
        end
    end
`else
    assign a_ready  = rdy_en_q && !full;
    assign push     = accept;
    assign push_rsp = new_rsp;
`endif

    logic unused_ok;
    assign unused_ok = ^{a_param, WAIT_CYCLES};

endmodule

// File: tb/tb_tlul_sram_slave.sv
module tb_tlul_sram_slave;

`ifdef TLUL_SLAVE_WAIT_STATES_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 1;
`endif

    logic        clk, reset;
    logic        a_valid, a_ready;
    logic [2:0]  a_opcode, a_param, a_size;
    logic [1:0]  a_source;
    logic [31:0] a_address, a_data;
    logic [3:0]  a_mask;
    logic        d_valid, d_ready;
    logic [2:0]  d_opcode, d_param, d_size;
    logic [1:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic        d_error;

    tlul_sram_slave dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_data(d_data),
        .d_error(d_error)
    );

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  size;
        logic [1:0]  src;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mdl [1024];
    int          checks = 0;
    int          errors = 0;
    int          dr_mode = 0;
    logic [31:0] last_d_data;
    logic [2:0]  last_d_op;
    logic        last_d_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference rules for which requests are erroneous (4-byte bus, 4 KiB window at 0).
    function automatic bit exp_err(input logic [2:0] op, input logic [2:0] sz,
                                   input logic [31:0] addr, input logic [3:0] mask);
        if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) return 1'b1;
        if (sz > 3'd2) return 1'b1;
        if ((addr % (32'd1 << sz)) != 0) return 1'b1;
        if (longint'(addr) >= 64'd4096) return 1'b1;
        if (op == 3'd0 && sz == 3'd2 && mask != 4'hF) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_accept(input logic [2:0] op, input logic [2:0] sz,
                                         input logic [1:0] src, input logic [31:0] addr,
                                         input logic [3:0] mask, input logic [31:0] data);
        exp_t e;
        int   w;
        e.err  = exp_err(op, sz, addr, mask);
        e.op   = (op == 3'd4) ? 3'd1 : 3'd0;
        e.size = sz;
        e.src  = src;
        e.data = 32'd0;
        w = int'(addr / 4);
        if (!e.err && op == 3'd4) e.data = mdl[w];
        if (!e.err && (op == 3'd0 || op == 3'd1)) begin
            for (int b = 0; b < 4; b++)
                if (mask[b]) mdl[w][8*b +: 8] = data[8*b +: 8];
        end
        exp_q.push_back(e);
    endfunction

    // d_ready driver: 0 = hold low, 1 = hold high, 2 = random each cycle.
    initial begin
        d_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (dr_mode == 2) d_ready = 1'($urandom_range(0, 1));
            else              d_ready = (dr_mode == 1);
        end
    end

    // D-channel scoreboard: every presented response must match the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && d_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL spurious_d observed=d_valid 1 expected=no response");
                end else begin
                    chk("d_rsp",
                        {19'd0, d_opcode, d_size, d_source, d_data, d_error, d_param, d_sink},
                        {19'd0, exp_q[0].op, exp_q[0].size, exp_q[0].src, exp_q[0].data,
                         exp_q[0].err, 3'd0, 1'b0});
                    if (d_ready === 1'b1) begin
                        last_d_data = d_data;
                        last_d_op   = d_opcode;
                        last_d_err  = d_error;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src,
                        input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        bit acc = 1'b0;
        @(posedge clk);
        #1;
        a_opcode = op; a_size = sz; a_source = src; a_address = addr;
        a_mask = mask; a_data = data; a_param = 3'($urandom); a_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (a_ready === 1'b1) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout observed=a_ready low expected=accept");
            a_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_accept(op, sz, src, addr, mask, data);
            #1 a_valid = 1'b0;
            for (int i = 0; i < LAT; i++) begin
                @(negedge clk);
`ifdef TLUL_SLAVE_WAIT_STATES_EN
                chk("wait_a_ready_low", 64'(a_ready), 64'd0);
`endif
            end
            chk("lat_d_valid", 64'(d_valid), 64'd1);
        end
    endtask

    task automatic drain();
        dr_mode = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0;
        a_source = '0; a_address = '0; a_mask = '0; a_data = '0;

        // Reset and release
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ready", 64'(a_ready), 64'd0);
        chk("rst_d_valid", 64'(d_valid), 64'd0);
        chk("rst_d_fields", 64'({d_opcode, d_size, d_source, d_data, d_error}), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rel_a_ready_low", 64'(a_ready), 64'd0);
        @(negedge clk);
        chk("rel_a_ready_high", 64'(a_ready), 64'd1);

        // Fill the first 16 words so every later read has defined content
        dr_mode = 1;
        for (int w = 0; w < 16; w++) send(3'd0, 3'd2, 2'(w), 32'(w * 4), 4'hF, $urandom);

        // Basic Put/Get
        send(3'd0, 3'd2, 2'd2, 32'h10, 4'hF, 32'hDEADBEEF);
        send(3'd4, 3'd2, 2'd1, 32'h10, 4'hF, 32'h0);
        drain();
        chk("get_deadbeef", 64'(last_d_data), 64'hDEADBEEF);

        send(3'd1, 3'd2, 2'd0, 32'h10, 4'b0011, 32'h12345678);
        send(3'd4, 3'd2, 2'd3, 32'h10, 4'hF, 32'h0);
        drain();
        chk("get_partial", 64'(last_d_data), 64'hDEAD5678);

        // Error cases
        send(3'd4, 3'd2, 2'd1, 32'h1000, 4'hF, 32'h0);
        drain();
        chk("err_range", 64'({last_d_op, last_d_err, last_d_data}), 64'({3'd1, 1'b1, 32'd0}));
        send(3'd3, 3'd2, 2'd0, 32'h0, 4'hF, 32'h0);
        drain();
        chk("err_opcode", 64'({last_d_op, last_d_err}), 64'({3'd0, 1'b1}));
        send(3'd0, 3'd2, 2'd1, 32'h2, 4'hF, 32'hCAFEF00D);
        drain();
        chk("err_misalign", 64'({last_d_op, last_d_err}), 64'({3'd0, 1'b1}));
        send(3'd4, 3'd2, 2'd1, 32'h0, 4'hF, 32'h0);
        drain();
        chk("mem_unchanged", 64'(last_d_data), 64'(mdl[0]));
        send(3'd4, 3'd3, 2'd2, 32'h0, 4'hF, 32'h0);
        send(3'd0, 3'd2, 2'd2, 32'h14, 4'h7, 32'h0BAD0BAD);
        send(3'd1, 3'd2, 2'd0, 32'h20, 4'h0, 32'h11111111);
        send(3'd4, 3'd2, 2'd0, 32'h20, 4'hF, 32'h0);
        send(3'd4, 3'd2, 2'd0, 32'h14, 4'hF, 32'h0);
        drain();

`ifndef TLUL_SLAVE_WAIT_STATES_EN
        // Backpressure: three back-to-back Gets with d_ready low
        dr_mode = 0;
        @(posedge clk);
        #1;
        a_valid = 1'b1; a_opcode = 3'd4; a_size = 3'd2; a_mask = 4'hF; a_data = '0;
        a_source = 2'd0; a_address = 32'h0;
        @(negedge clk);
        chk("bb_rdy1", 64'(a_ready), 64'd1);
        @(posedge clk);
        model_accept(3'd4, 3'd2, 2'd0, 32'h0, 4'hF, 32'h0);
        #1 a_source = 2'd1; a_address = 32'h4;
        @(negedge clk);
        chk("bb_rdy2", 64'(a_ready), 64'd1);
        @(posedge clk);
        model_accept(3'd4, 3'd2, 2'd1, 32'h4, 4'hF, 32'h0);
        #1 a_source = 2'd2; a_address = 32'h8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bb_full_rdy_low", 64'(a_ready), 64'd0);
        end
        @(posedge clk);
        #1 dr_mode = 1;
        @(negedge clk);
        chk("bb_rdy_low_at_pop", 64'(a_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("bb_rdy_after_pop", 64'(a_ready), 64'd1);
        @(posedge clk);
        model_accept(3'd4, 3'd2, 2'd2, 32'h8, 4'hF, 32'h0);
        #1 a_valid = 1'b0;
        drain();
`endif

        // Asynchronous reset with two responses queued
        dr_mode = 0;
        send(3'd4, 3'd2, 2'd0, 32'h0, 4'hF, 32'h0);
        send(3'd4, 3'd2, 2'd1, 32'h4, 4'hF, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("arst_d_valid", 64'(d_valid), 64'd0);
        chk("arst_a_ready", 64'(a_ready), 64'd0);
        chk("arst_d_data", 64'(d_data), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("arst_rel_rdy_low", 64'(a_ready), 64'd0);
        @(negedge clk);
        chk("arst_rel_rdy_high", 64'(a_ready), 64'd1);
        chk("arst_rel_empty", 64'(d_valid), 64'd0);

        // Randomized traffic with random D backpressure
        dr_mode = 2;
        for (int n = 0; n < 80; n++) begin
            int          r, w, off, sz;
            logic [2:0]  op;
            logic [31:0] addr;
            logic [3:0]  mask;
            r = $urandom_range(0, 19);
            if (r < 8)       op = 3'd4;
            else if (r < 13) op = 3'd0;
            else if (r < 18) op = 3'd1;
            else if (r == 18) op = 3'd2 + 3'($urandom_range(0, 1));
            else             op = 3'd5 + 3'($urandom_range(0, 2));
            sz  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            w   = $urandom_range(0, 15);
            off = $urandom_range(0, 3);
            if ($urandom_range(0, 4) != 0) off = off & ~((1 << sz) - 1);
            addr = 32'(w * 4 + off);
            if ($urandom_range(0, 14) == 0) addr = 32'h1000 + 32'(w * 4);
            mask = (op == 3'd0 && $urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
            send(op, 3'(sz), 2'($urandom), addr, mask, $urandom);
        end
        for (int w = 0; w < 16; w++) send(3'd4, 3'd2, 2'(w), 32'(w * 4), 4'hF, 32'h0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
